// File: rtl/d_mem_pkg.sv
// Shared definitions for the byte-enabled data memory.
// Size encodings, FSM states and the alignment rule.
package d_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] lane
  );
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      SZ_WORD: return lane == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_lane_fmt.sv
// Lane steering: load extraction/extension, byte enables
// and store data replication for one 32-bit word.
module d_mem_lane_fmt
  import d_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] st_data
);

  logic [31:0] sh;

  assign sh = raw >> {lane, 3'b000};

  always_comb begin
    ld_data = sh;
    be      = 4'b0000;
    st_data = wdata;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{sign_ext & sh[7]}}, sh[7:0]};
        be      = 4'b0001 << lane;
        st_data = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        ld_data = {{16{sign_ext & sh[15]}}, sh[15:0]};
        be      = 4'b0011 << lane;
        st_data = {2{wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/d_mem_be.sv
// Data memory with byte/half/word access, wait states
// and a req/ready handshake behind the MEM stage.
module d_mem_be
  import d_mem_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign,
  output logic        busy
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t          state;
  logic [3:0]      cnt;
  logic            err;
  logic            we_q;
  logic            sext_q;
  logic [1:0]      size_q;
  logic [1:0]      lane_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [MEM_WORDS];
  logic            commit;
  logic [31:0]     raw;
  logic [31:0]     ld_data;
  logic [31:0]     st_data;
  logic [3:0]      be;
  logic            unused_addr;

  // Upper address bits are dropped so accesses wrap.
  assign unused_addr = ^addr[31:AW+2];

  assign commit = (state == WAIT) && (cnt == 4'd0);
  assign busy   = state != IDLE;
  assign raw    = mem[idx_q];

  d_mem_lane_fmt u_fmt (
    .raw      (raw),
    .lane     (lane_q),
    .size     (size_q),
    .sign_ext (sext_q),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .be       (be),
    .st_data  (st_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      err      <= 1'b0;
      we_q     <= 1'b0;
      sext_q   <= 1'b0;
      size_q   <= SZ_WORD;
      lane_q   <= 2'b00;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      rdata    <= 32'd0;
      ready    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      ready    <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (is_aligned(size, addr[1:0])) begin
              we_q    <= we;
              sext_q  <= sign_ext;
              size_q  <= size;
              lane_q  <= addr[1:0];
              idx_q   <= addr[AW+1:2];
              wdata_q <= wdata;
              cnt     <= 4'(WAIT_STATES);
              err     <= 1'b0;
              state   <= WAIT;
            end else begin
              err      <= 1'b1;
              ready    <= 1'b1;
              misalign <= 1'b1;
              state    <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q) rdata <= ld_data;
            ready    <= 1'b1;
            misalign <= err;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Contents are not reset; only the enabled lanes change.
  always_ff @(posedge clock) begin
    if (commit && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_d_mem_be.sv
// Scoreboard bench for d_mem_be: byte-level reference
// memory, directed cases, reset-in-WAIT and random ops.
module tb_d_mem_be;
  import d_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset_a, reset_b;
  logic        req_a, req_b;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b;
  logic        misalign_a, misalign_b;
  logic        busy_a, busy_b;

  always #5 clock = ~clock;

  d_mem_be #(.MEM_WORDS(1024), .WAIT_STATES(1)) dut_a (
    .clock(clock), .reset(reset_a), .req(req_a), .we(we),
    .size(size), .sign_ext(sign_ext), .addr(addr),
    .wdata(wdata), .rdata(rdata_a), .ready(ready_a),
    .misalign(misalign_a), .busy(busy_a)
  );

  d_mem_be #(.MEM_WORDS(1024), .WAIT_STATES(3)) dut_b (
    .clock(clock), .reset(reset_b), .req(req_b), .we(we),
    .size(size), .sign_ext(sign_ext), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .ready(ready_b),
    .misalign(misalign_b), .busy(busy_b)
  );

  typedef struct {
    int          due;
    logic        mis;
    logic [31:0] rd;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [7:0]  mb [2][4096];
  logic [31:0] mrd [2];
  int          pass_cnt = 0;
  int          total = 0;
  int          cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int ws(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: byte array indexed modulo 4 KiB.
  function automatic exp_t model_op(input int d, input bit w,
      input logic [1:0] sz, input bit sx,
      input logic [31:0] ad, input logic [31:0] wd);
    exp_t        e;
    int          n, ba;
    bit          legal;
    logic [31:0] v;
    n = 1 << sz;
    legal = (sz != 2'd3) && ((int'(ad[1:0]) % n) == 0);
    ba = int'(ad % 32'd4096);
    e.due = cyc + 1 + (legal ? 1 + ws(d) : 0);
    e.mis = !legal;
    if (legal) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[d][ba+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][ba+i];
        if (sx && n < 4 && v[8*n-1])
          for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
        mrd[d] = v;
      end
    end
    e.rd = mrd[d];
    return e;
  endfunction

  always @(negedge clock) begin
    if (ready_a) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL unexpected_ready_a: ready=1 required 0");
      end else begin
        ea = qa.pop_front();
        chk("a_ready_cycle", 32'(cyc), 32'(ea.due));
        chk("a_misalign", 32'(misalign_a), 32'(ea.mis));
        chk("a_rdata", rdata_a, ea.rd);
        chk("a_busy_done", 32'(busy_a), 32'd1);
      end
    end
    if (ready_b) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL unexpected_ready_b: ready=1 required 0");
      end else begin
        eb = qb.pop_front();
        chk("b_ready_cycle", 32'(cyc), 32'(eb.due));
        chk("b_misalign", 32'(misalign_b), 32'(eb.mis));
        chk("b_rdata", rdata_b, eb.rd);
      end
    end
  end

  task automatic wait_done(input int d, input bit noise);
    for (int i = 0; i < 64; i++) begin
      if ((d == 0 ? qa.size() : qb.size()) == 0) begin
        req_a = 1'b0;
        return;
      end
      // Requests while busy must be ignored.
      if (noise && d == 0) begin
        req_a    = 1'($urandom);
        we       = 1'($urandom);
        size     = 2'($urandom);
        sign_ext = 1'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
      end
      @(negedge clock); #1;
    end
    req_a = 1'b0;
    total++;
    $display("FAIL timeout_dut%0d: ready=0 required 1 within 64 cycles", d);
    if (d == 0) qa.delete(); else qb.delete();
  endtask

  task automatic do_op(input int d, input bit w, input logic [1:0] sz,
      input bit sx, input logic [31:0] ad, input logic [31:0] wd,
      input bit noise);
    exp_t e;
    @(negedge clock); #1;
    we = w; size = sz; sign_ext = sx; addr = ad; wdata = wd;
    if (d == 0) req_a = 1'b1; else req_b = 1'b1;
    e = model_op(d, w, sz, sx, ad, wd);
    if (d == 0) qa.push_back(e); else qb.push_back(e);
    @(negedge clock); #1;
    req_a = 1'b0;
    req_b = 1'b0;
    wait_done(d, noise);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rcount;
    reset_a = 1'b1; reset_b = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    mrd[0] = 32'd0; mrd[1] = 32'd0;
    repeat (3) @(negedge clock);
    chk("a_rst_rdata", rdata_a, 32'd0);
    chk("a_rst_ready", 32'(ready_a), 32'd0);
    chk("a_rst_misalign", 32'(misalign_a), 32'd0);
    chk("a_rst_busy", 32'(busy_a), 32'd0);
    chk("b_rst_rdata", rdata_b, 32'd0);
    chk("b_rst_ready", 32'(ready_b), 32'd0);
    chk("b_rst_busy", 32'(busy_b), 32'd0);
    reset_a = 1'b0; reset_b = 1'b0;

    do_op(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0);
    do_op(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 0);
    chk("dir_word_load", rdata_a, 32'hDEADBEEF);

    do_op(0, 1, SZ_WORD, 0, 32'h20, 32'h11223344, 0);
    do_op(0, 1, SZ_BYTE, 0, 32'h22, 32'h123456AA, 0);
    do_op(0, 0, SZ_WORD, 0, 32'h20, 32'h0, 0);
    chk("dir_byte_merge", rdata_a, 32'h11AA3344);

    do_op(0, 1, SZ_WORD, 0, 32'h30, 32'h0000FF80, 0);
    do_op(0, 0, SZ_HALF, 1, 32'h30, 32'h0, 0);
    chk("dir_half_signed", rdata_a, 32'hFFFFFF80);
    do_op(0, 0, SZ_BYTE, 0, 32'h31, 32'h0, 0);
    chk("dir_byte_unsigned", rdata_a, 32'h000000FF);
    do_op(0, 0, SZ_BYTE, 1, 32'h30, 32'h0, 0);
    chk("dir_byte_signed", rdata_a, 32'hFFFFFF80);

    do_op(0, 0, SZ_HALF, 1, 32'h03, 32'h0, 0);
    chk("err_half_rdata", rdata_a, 32'hFFFFFF80);
    do_op(0, 1, SZ_WORD, 0, 32'h22, 32'hFFFFFFFF, 0);
    do_op(0, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 0);
    do_op(0, 0, SZ_WORD, 0, 32'h20, 32'h0, 0);
    chk("err_mem_unchanged", rdata_a, 32'h11AA3344);

    do_op(0, 1, SZ_WORD, 0, 32'h1000, 32'h55, 0);
    do_op(0, 0, SZ_WORD, 0, 32'h0, 32'h0, 0);
    chk("wrap_load", rdata_a, 32'h55);

    do_op(1, 1, SZ_WORD, 0, 32'h40, 32'h0, 0);
    do_op(1, 1, SZ_WORD, 0, 32'h44, 32'h12345678, 0);
    do_op(1, 0, SZ_WORD, 0, 32'h44, 32'h0, 0);
    @(negedge clock); #1;
    we = 1'b1; size = SZ_WORD; sign_ext = 1'b0;
    addr = 32'h40; wdata = 32'hCAFEF00D; req_b = 1'b1;
    @(posedge clock); #1;
    req_b = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    chk("b_busy_in_wait", 32'(busy_b), 32'd1);
    reset_b = 1'b1;
    #1;
    chk("b_busy_after_rst", 32'(busy_b), 32'd0);
    chk("b_rdata_after_rst", rdata_b, 32'd0);
    mrd[1] = 32'd0;
    @(negedge clock);
    reset_b = 1'b0;
    rcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ready_b) rcount++;
    end
    chk("b_no_ready_after_rst", 32'(rcount), 32'd0);
    do_op(1, 0, SZ_WORD, 0, 32'h40, 32'h0, 0);
    chk("b_store_dropped", rdata_b, 32'h0);

    for (int w = 0; w < 16; w++)
      do_op(0, 1, SZ_WORD, 0, 32'(4*w), $urandom, 0);
    for (int i = 0; i < 150; i++)
      do_op(0, 1'($urandom), 2'($urandom), 1'($urandom),
            ($urandom & 32'hFFFF_F000) | ($urandom % 64),
            $urandom, 1);

    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
